refill_ctrl: RTL and testbench
==============================

# refill_ctrl

Miss-handling engine for the L1 data cache. Accepts one line miss at a time and reads the replacement policy's victim way and the victim line's state. It writes back the victim if it is dirty, fetches the new line from memory, and installs data and tag. It then reports the filled way to the replacement policy as an access (access_en/access_index/access_way), so the policy's victim pointer for that set advances. It sits between the cache pipeline's miss port, the tag/data arrays, the replacement-policy block, and the memory interface.

## Interface
- NUM_SETS, 64, sets per way
- NUM_WAYS, 4, associativity
- INDEX_BITS, $clog2(NUM_SETS), set index width
- WAY_BITS, (NUM_WAYS>1)?$clog2(NUM_WAYS):1, way select width
- TAG_BITS, 20, tag width
- LINE_WORDS, 4, words per line (power of two, ≥2)
- WORD_BITS, $clog2(LINE_WORDS), word offset width
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, TAG_BITS+INDEX_BITS+WORD_BITS, word-granular memory address

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset: synchronous and active-low, single clock domain
- miss_valid / miss_ready  in / out  1 / 1  miss request handshake
- miss_index, miss_tag  in  INDEX_BITS, TAG_BITS  missing line
- repl_index  out  INDEX_BITS  set presented to policy and tag/data arrays (victim lookup)
- victim_way  in  WAY_BITS  policy victim for repl_index (combinational)
- victim_valid, victim_dirty  in  1, 1  tag state of (repl_index, victim_way)
- victim_tag  in  TAG_BITS  tag of that line
- victim_line  in  LINE_WORDS*DATA_WIDTH  data of that line, word 0 in LSBs
- repl_en, repl_way  out  1, WAY_BITS  access update to policy (index = repl_index)
- mem_wr_valid / mem_wr_ready  out / in  1 / 1  writeback beat handshake
- mem_wr_addr, mem_wr_data  out  ADDR_WIDTH, DATA_WIDTH
- mem_rd_req_valid / mem_rd_req_ready  out / in  1 / 1  line read request
- mem_rd_addr  out  ADDR_WIDTH  line base address, word offset 0
- mem_rd_resp_valid, mem_rd_data  in  1, DATA_WIDTH  read beats, in order, no backpressure
- fill_we, fill_way, fill_word, fill_data  out  1, WAY_BITS, WORD_BITS, DATA_WIDTH  data array write at repl_index
- tag_we, tag_wr_valid, tag_wr_tag  out  1, 1, TAG_BITS  tag write at (repl_index, fill_way); dirty cleared on any tag_we
- refill_done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, VICTIM, WB, RDREQ, FILL, DONE.
- IDLE: miss_ready=1. On miss_valid, latch index/tag and go to VICTIM. repl_index = latched index at all times.
- VICTIM (1 cycle): capture victim_way, victim_valid&victim_dirty, victim_tag, victim_line. Pulse tag_we with tag_wr_valid=0 to invalidate the victim before overwrite.
  - Dirty victim → WB.
  - Otherwise → RDREQ.
- WB: present word w_cnt. Address = {victim_tag, index, w_cnt}; data = captured word w_cnt. w_cnt increments on mem_wr_valid&&mem_wr_ready. The beat with w_cnt=LINE_WORDS-1 accepted → RDREQ, w_cnt=0.
- RDREQ: mem_rd_req_valid=1, mem_rd_addr={miss_tag, index, 0}. Held stable until ready. Handshake → FILL.
- FILL: each mem_rd_resp_valid produces fill_we=1 in the same cycle, with fill_word=w_cnt and fill_data=mem_rd_data; then w_cnt++. The last beat → DONE.
- DONE (1 cycle): tag_we=1, tag_wr_valid=1, tag_wr_tag=latched tag. repl_en=1, repl_way=captured way. refill_done=1. Then → IDLE.
- fill_way = captured victim way in VICTIM through DONE.
- Boundary conditions:
  - mem_rd_resp_valid outside FILL is ignored.
  - mem_wr_ready outside WB is ignored.
  - miss_valid while busy is not accepted and must be held by the source.
  - A word counter wrap never occurs mid-burst.
- Reset, including mid-operation: state IDLE, counters 0, all outputs 0 except miss_ready=1. A line invalidated in VICTIM stays invalid. No partial tag is installed.

## Timing
- Outputs are registered-state decodes. The address/data buses are combinational from registers only.
- Clean miss, all ready, one response per cycle. Acceptance = cycle 0; VICTIM 1; RDREQ handshake 2; fill beats 3–6; refill_done 7.
- Dirty miss, same conditions: WB beats 2–5; RDREQ 6; fills 7–10; refill_done 11.
- Back-to-back: the next miss can be accepted in the cycle after DONE.
- repl_en pulses exactly once per miss.

## Test plan
- Clean miss index 5, tag 0x00ABC, victim_valid=0, responses D0..D3 → no mem_wr_valid; mem_rd_addr={0x00ABC,5,0}; fill_we words 0..3; tag_we valid=1 tag 0x00ABC; repl_en way=victim_way; done at cycle 7.
- Dirty victim tag 0x00123 at index 5 → invalidate pulse in cycle 1; four writes at {0x00123,5,0..3} carrying captured words; then read; done at cycle 11.
- Stalls: hold mem_wr_ready=0 for 3 cycles on beat 2 and mem_rd_req_ready=0 for 2 cycles → address/data held stable; no beat duplicated or skipped; done delayed by exactly 5 cycles.
- Gapped responses (one beat every 3 cycles) plus a stray response in IDLE → only 4 fill_we; stray ignored.
- miss_valid held during busy → miss_ready=0 until after DONE; second miss accepted the following cycle.
- rst_n low mid-FILL after beat 1 → IDLE next cycle, all outputs 0, miss_ready=1; no tag_we valid=1 and no repl_en emitted.

Source files
------------

// File: rtl/refill_ctrl.sv
// L1 data-cache miss handler: invalidates the victim, writes it back when dirty,
// fetches the missing line, installs data and tag, then reports the access to the policy.
module refill_ctrl #(
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 4,
    parameter int INDEX_BITS = $clog2(NUM_SETS),
    parameter int WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    parameter int TAG_BITS   = 20,
    parameter int LINE_WORDS = 4,
    parameter int WORD_BITS  = $clog2(LINE_WORDS),
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = TAG_BITS + INDEX_BITS + WORD_BITS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             miss_valid_i,
    output logic                             miss_ready_o,
    input  logic [INDEX_BITS-1:0]            miss_index_i,
    input  logic [TAG_BITS-1:0]              miss_tag_i,
    output logic [INDEX_BITS-1:0]            repl_index_o,
    input  logic [WAY_BITS-1:0]              victim_way_i,
    input  logic                             victim_valid_i,
    input  logic                             victim_dirty_i,
    input  logic [TAG_BITS-1:0]              victim_tag_i,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] victim_line_i,
    output logic                             repl_en_o,
    output logic [WAY_BITS-1:0]              repl_way_o,
    output logic                             mem_wr_valid_o,
    input  logic                             mem_wr_ready_i,
    output logic [ADDR_WIDTH-1:0]            mem_wr_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_wr_data_o,
    output logic                             mem_rd_req_valid_o,
    input  logic                             mem_rd_req_ready_i,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr_o,
    input  logic                             mem_rd_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]            mem_rd_data_i,
    output logic                             fill_we_o,
    output logic [WAY_BITS-1:0]              fill_way_o,
    output logic [WORD_BITS-1:0]             fill_word_o,
    output logic [DATA_WIDTH-1:0]            fill_data_o,
    output logic                             tag_we_o,
    output logic                             tag_wr_valid_o,
    output logic [TAG_BITS-1:0]              tag_wr_tag_o,
    output logic                             refill_done_o,
    output logic                             busy_o
);

    typedef enum logic [2:0] {IDLE, VICTIM, WB, RDREQ, FILL, DONE} state_t;

    state_t                           state_q, state_d;
    logic [INDEX_BITS-1:0]            index_q, index_d;
    logic [TAG_BITS-1:0]              tag_q, tag_d;
    logic [TAG_BITS-1:0]              vtag_q, vtag_d;
    logic [WAY_BITS-1:0]              way_q, way_d;
    logic [LINE_WORDS*DATA_WIDTH-1:0] line_q, line_d;
    logic [WORD_BITS-1:0]             w_cnt_q, w_cnt_d;
    logic [DATA_WIDTH-1:0]            line_words [LINE_WORDS];
    logic                             last_word;

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
        assign line_words[gi] = line_q[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign last_word    = (w_cnt_q == WORD_BITS'(LINE_WORDS - 1));
    assign repl_index_o = index_q;
    assign busy_o       = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            way_q   <= '0;
            line_q  <= '0;
            w_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            tag_q   <= tag_d;
            vtag_q  <= vtag_d;
            way_q   <= way_d;
            line_q  <= line_d;
            w_cnt_q <= w_cnt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        index_d            = index_q;
        tag_d              = tag_q;
        vtag_d             = vtag_q;
        way_d              = way_q;
        line_d             = line_q;
        w_cnt_d            = w_cnt_q;
        miss_ready_o       = 1'b0;
        repl_en_o          = 1'b0;
        repl_way_o         = '0;
        mem_wr_valid_o     = 1'b0;
        mem_wr_addr_o      = '0;
        mem_wr_data_o      = '0;
        mem_rd_req_valid_o = 1'b0;
        mem_rd_addr_o      = '0;
        fill_we_o          = 1'b0;
        fill_way_o         = '0;
        fill_word_o        = '0;
        fill_data_o        = '0;
        tag_we_o           = 1'b0;
        tag_wr_valid_o     = 1'b0;
        tag_wr_tag_o       = '0;
        refill_done_o      = 1'b0;

        if (state_q != IDLE) begin
            fill_way_o = way_q;
        end

        case (state_q)
            IDLE: begin
                miss_ready_o = 1'b1;
                if (miss_valid_i) begin
                    index_d = miss_index_i;
                    tag_d   = miss_tag_i;
                    state_d = VICTIM;
                end
            end
            VICTIM: begin
                // Victim is invalidated before any data is overwritten, so a reset
                // later in the refill can never expose a half-filled line as valid.
                tag_we_o   = 1'b1;
                fill_way_o = victim_way_i;
                way_d      = victim_way_i;
                vtag_d     = victim_tag_i;
                line_d     = victim_line_i;
                w_cnt_d    = '0;
                state_d    = (victim_valid_i && victim_dirty_i) ? WB : RDREQ;
            end
            WB: begin
                mem_wr_valid_o = 1'b1;
                mem_wr_addr_o  = {vtag_q, index_q, w_cnt_q};
                mem_wr_data_o  = line_words[w_cnt_q];
                if (mem_wr_ready_i) begin
                    w_cnt_d = w_cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = RDREQ;
                    end
                end
            end
            RDREQ: begin
                mem_rd_req_valid_o = 1'b1;
                mem_rd_addr_o      = {tag_q, index_q, {WORD_BITS{1'b0}}};
                if (mem_rd_req_ready_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_rd_resp_valid_i) begin
                    fill_we_o   = 1'b1;
                    fill_word_o = w_cnt_q;
                    fill_data_o = mem_rd_data_i;
                    w_cnt_d     = w_cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                tag_we_o       = 1'b1;
                tag_wr_valid_o = 1'b1;
                tag_wr_tag_o   = tag_q;
                repl_en_o      = 1'b1;
                repl_way_o     = way_q;
                refill_done_o  = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_refill_ctrl.sv
// Bench for refill_ctrl: behavioural cache/policy/memory environment, a vector
// table for the directed scenarios, and randomized misses against a transaction model.
module tb_refill_ctrl;

    localparam int NS = 64, NW = 4, IDXW = 6, WAYW = 2, TAGW = 20;
    localparam int LW = 4, WDW = 2, DW = 32, AW = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n = 1'b0;
    logic                miss_valid = 1'b0, miss_ready;
    logic [IDXW-1:0]     miss_index = '0, repl_index;
    logic [TAGW-1:0]     miss_tag = '0;
    logic [WAYW-1:0]     victim_way;
    logic                victim_valid, victim_dirty;
    logic [TAGW-1:0]     victim_tag;
    logic [LW*DW-1:0]    victim_line;
    logic                repl_en;
    logic [WAYW-1:0]     repl_way;
    logic                mem_wr_valid, mem_wr_ready = 1'b0;
    logic [AW-1:0]       mem_wr_addr, mem_rd_addr;
    logic [DW-1:0]       mem_wr_data;
    logic                mem_rd_req_valid, mem_rd_req_ready = 1'b0;
    logic                mem_rd_resp_valid = 1'b0;
    logic [DW-1:0]       mem_rd_data = '0;
    logic                fill_we;
    logic [WAYW-1:0]     fill_way;
    logic [WDW-1:0]      fill_word;
    logic [DW-1:0]       fill_data;
    logic                tag_we, tag_wr_valid;
    logic [TAGW-1:0]     tag_wr_tag;
    logic                refill_done, busy;

    refill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid_i(miss_valid), .miss_ready_o(miss_ready),
        .miss_index_i(miss_index), .miss_tag_i(miss_tag),
        .repl_index_o(repl_index),
        .victim_way_i(victim_way), .victim_valid_i(victim_valid), .victim_dirty_i(victim_dirty),
        .victim_tag_i(victim_tag), .victim_line_i(victim_line),
        .repl_en_o(repl_en), .repl_way_o(repl_way),
        .mem_wr_valid_o(mem_wr_valid), .mem_wr_ready_i(mem_wr_ready),
        .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
        .mem_rd_req_valid_o(mem_rd_req_valid), .mem_rd_req_ready_i(mem_rd_req_ready),
        .mem_rd_addr_o(mem_rd_addr),
        .mem_rd_resp_valid_i(mem_rd_resp_valid), .mem_rd_data_i(mem_rd_data),
        .fill_we_o(fill_we), .fill_way_o(fill_way), .fill_word_o(fill_word), .fill_data_o(fill_data),
        .tag_we_o(tag_we), .tag_wr_valid_o(tag_wr_valid), .tag_wr_tag_o(tag_wr_tag),
        .refill_done_o(refill_done), .busy_o(busy)
    );

    // Cache arrays and round-robin policy seen by the DUT.
    logic            env_valid [NS][NW];
    logic            env_dirty [NS][NW];
    logic [TAGW-1:0] env_tag   [NS][NW];
    logic [DW-1:0]   env_data  [NS][NW][LW];
    logic [WAYW-1:0] env_ptr   [NS];

    assign victim_way   = env_ptr[repl_index];
    assign victim_valid = env_valid[repl_index][victim_way];
    assign victim_dirty = env_dirty[repl_index][victim_way];
    assign victim_tag   = env_tag[repl_index][victim_way];
    always_comb begin
        victim_line = '0;
        for (int w = 0; w < LW; w++) victim_line[w*DW +: DW] = env_data[repl_index][victim_way][w];
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Array writes seen in a cycle land just after the next clock edge.
    logic            pf_v = 0, pt_v = 0, pr_v = 0, pt_valid;
    logic [IDXW-1:0] pf_idx, pt_idx, pr_idx;
    logic [WAYW-1:0] pf_way, pt_way, pr_way;
    logic [WDW-1:0]  pf_word;
    logic [DW-1:0]   pf_data;
    logic [TAGW-1:0] pt_tag;

    task automatic apply_pending();
        if (pf_v) begin env_data[pf_idx][pf_way][pf_word] = pf_data; pf_v = 0; end
        if (pt_v) begin
            env_valid[pt_idx][pt_way] = pt_valid;
            env_dirty[pt_idx][pt_way] = 1'b0;
            if (pt_valid) env_tag[pt_idx][pt_way] = pt_tag;
            pt_v = 0;
        end
        if (pr_v) begin env_ptr[pr_idx] = pr_way + 1'b1; pr_v = 0; end
    endtask

    int  cfg_wst[4], cfg_gap[4], cfg_rst, cfg_abort;
    bit  cfg_hold, cfg_stray;
    logic [DW-1:0] rdata[4];

    typedef struct { logic v; logic [TAGW-1:0] tag; logic [WAYW-1:0] way; int cyc; } tw_t;
    logic [AW-1:0]   obs_wb_addr[$];
    logic [DW-1:0]   obs_wb_data[$];
    logic [WDW-1:0]  obs_fill_word[$];
    logic [DW-1:0]   obs_fill_data[$];
    logic [WAYW-1:0] obs_fill_way[$];
    tw_t             obs_tw[$];
    int              obs_rd_cnt, obs_repl_cnt, obs_done, obs_acc_wait;
    logic [AW-1:0]   obs_rd_addr;
    logic [WAYW-1:0] obs_repl_way;
    bit              obs_ready_bad, obs_unstable;

    logic [WAYW-1:0] e_way;
    bit              e_dirty;
    logic [TAGW-1:0] e_vt;
    logic [DW-1:0]   e_vline[4];
    int              e_done;

    // Transaction-level expectation from the environment state before the miss.
    task automatic prep_expect(input logic [IDXW-1:0] idx);
        e_way   = env_ptr[idx];
        e_dirty = env_valid[idx][e_way] && env_dirty[idx][e_way];
        e_vt    = env_tag[idx][e_way];
        for (int w = 0; w < LW; w++) e_vline[w] = env_data[idx][e_way][w];
        e_done = 1 + cfg_rst + 1 + 1;
        for (int b = 0; b < LW; b++) begin
            e_done += cfg_gap[b] + 1;
            if (e_dirty) e_done += cfg_wst[b] + 1;
        end
    endtask

    task automatic run_miss(input logic [IDXW-1:0] idx, input logic [TAGW-1:0] tag);
        int wb_n = 0, wcnt = 0, rcnt = 0, sent = 0, gcnt = 0, c = 0;
        bit accepted = 0, fin = 0, rd_seen = 0, real_resp, stray, pw_stall = 0, pr_stall = 0;
        logic [AW-1:0] pw_addr = '0, pr_addr = '0;
        logic [DW-1:0] pw_data = '0;
        obs_wb_addr.delete(); obs_wb_data.delete(); obs_fill_word.delete();
        obs_fill_data.delete(); obs_fill_way.delete(); obs_tw.delete();
        obs_rd_cnt = 0; obs_repl_cnt = 0; obs_done = -1; obs_acc_wait = -1;
        obs_ready_bad = 0; obs_unstable = 0; obs_rd_addr = '0; obs_repl_way = '0;
        for (int t = 0; t < 300 && !fin; t++) begin
            @(posedge clk); #1;
            apply_pending();
            if (!accepted) begin miss_valid = 1; miss_index = idx; miss_tag = tag; end
            else if (!cfg_hold) miss_valid = 0;
            mem_wr_ready     = mem_wr_valid && ((wb_n < 4) ? (wcnt >= cfg_wst[wb_n]) : 1'b0);
            mem_rd_req_ready = mem_rd_req_valid && (rcnt >= cfg_rst);
            real_resp        = rd_seen && (sent < 4) && ((sent < 4) ? (gcnt >= cfg_gap[sent]) : 1'b0);
            stray            = !rd_seen && cfg_stray && ($urandom_range(0, 2) == 0);
            mem_rd_resp_valid = real_resp || stray;
            mem_rd_data       = real_resp ? rdata[sent] : $urandom;
            #4;
            if (accepted) c++;
            if (accepted && busy && miss_ready) obs_ready_bad = 1;
            if (mem_wr_valid) begin
                if (pw_stall && (mem_wr_addr !== pw_addr || mem_wr_data !== pw_data)) obs_unstable = 1;
                if (mem_wr_ready) begin
                    obs_wb_addr.push_back(mem_wr_addr); obs_wb_data.push_back(mem_wr_data);
                    wb_n++; wcnt = 0;
                end else wcnt++;
                pw_stall = !mem_wr_ready; pw_addr = mem_wr_addr; pw_data = mem_wr_data;
            end else pw_stall = 0;
            if (real_resp) begin sent++; gcnt = 0; end
            else if (rd_seen) gcnt++;
            if (mem_rd_req_valid) begin
                if (pr_stall && mem_rd_addr !== pr_addr) obs_unstable = 1;
                if (mem_rd_req_ready) begin obs_rd_cnt++; obs_rd_addr = mem_rd_addr; rd_seen = 1; end
                else rcnt++;
                pr_stall = !mem_rd_req_ready; pr_addr = mem_rd_addr;
            end else pr_stall = 0;
            if (fill_we) begin
                obs_fill_word.push_back(fill_word); obs_fill_data.push_back(fill_data);
                obs_fill_way.push_back(fill_way);
                pf_v = 1; pf_idx = repl_index; pf_way = fill_way; pf_word = fill_word; pf_data = fill_data;
            end
            if (tag_we) begin
                obs_tw.push_back('{tag_wr_valid, tag_wr_tag, fill_way, c});
                pt_v = 1; pt_idx = repl_index; pt_way = fill_way; pt_valid = tag_wr_valid; pt_tag = tag_wr_tag;
            end
            if (repl_en) begin
                obs_repl_cnt++; obs_repl_way = repl_way;
                pr_v = 1; pr_idx = repl_index; pr_way = repl_way;
            end
            if (refill_done) begin obs_done = c; fin = 1; end
            if (!accepted && miss_ready && miss_valid) begin accepted = 1; obs_acc_wait = t; c = 0; end
            if (cfg_abort > 0 && sent >= cfg_abort) fin = 1;
        end
        mem_wr_ready = 0; mem_rd_req_ready = 0; mem_rd_resp_valid = 0;
        apply_pending();
    endtask

    task automatic check_miss(input logic [IDXW-1:0] idx, input logic [TAGW-1:0] tag);
        int bad;
        chk("wb_count", obs_wb_addr.size(), e_dirty ? 4 : 0);
        bad = 0;
        for (int b = 0; b < obs_wb_addr.size() && b < 4; b++)
            if (obs_wb_addr[b] !== ((AW'(e_vt) << 8) | (AW'(idx) << 2) | AW'(b)) || obs_wb_data[b] !== e_vline[b]) bad++;
        chk("wb_beats", bad, 0);
        chk("rd_req_count", obs_rd_cnt, 1);
        chk("rd_addr", obs_rd_addr, (AW'(tag) << 8) | (AW'(idx) << 2));
        chk("fill_count", obs_fill_word.size(), 4);
        bad = 0;
        for (int k = 0; k < obs_fill_word.size() && k < 4; k++)
            if (obs_fill_word[k] !== WDW'(k) || obs_fill_data[k] !== rdata[k] || obs_fill_way[k] !== e_way) bad++;
        chk("fill_beats", bad, 0);
        chk("tag_write_count", obs_tw.size(), 2);
        bad = 0;
        if (obs_tw.size() >= 1 && (obs_tw[0].v !== 1'b0 || obs_tw[0].way !== e_way || obs_tw[0].cyc != 1)) bad++;
        if (obs_tw.size() >= 2 && (obs_tw[1].v !== 1'b1 || obs_tw[1].tag !== tag ||
                                   obs_tw[1].way !== e_way || obs_tw[1].cyc != e_done)) bad++;
        chk("tag_writes", bad, 0);
        chk("repl_count", obs_repl_cnt, 1);
        chk("repl_way", obs_repl_way, e_way);
        chk("done_cycle", obs_done, e_done);
        chk("ready_while_busy", obs_ready_bad, 0);
        chk("bus_stable_on_stall", obs_unstable, 0);
        $display("miss idx=%0d tag=0x%05h way=%0d dirty=%0d done_cycle=%0d", idx, tag, e_way, e_dirty, obs_done);
    endtask

    typedef struct {
        logic [IDXW-1:0] idx; logic [TAGW-1:0] tag; bit vvalid; bit vdirty; logic [TAGW-1:0] vtag;
        logic [WAYW-1:0] way; int wst2; int rst; int gap; int exp_done; int exp_wb; logic [AW-1:0] exp_rdaddr;
    } vec_t;
    vec_t vecs[4];

    initial begin
        vecs[0] = '{6'd5, 20'h00ABC, 1'b0, 1'b0, 20'h00000, 2'd2, 0, 0, 0,  7, 0, 28'h0ABC14};
        vecs[1] = '{6'd5, 20'h00456, 1'b1, 1'b1, 20'h00123, 2'd1, 0, 0, 0, 11, 4, 28'h045614};
        vecs[2] = '{6'd9, 20'h00777, 1'b1, 1'b1, 20'h0F0F0, 2'd3, 3, 2, 0, 16, 4, 28'h077724};
        vecs[3] = '{6'd5, 20'h00ABC, 1'b1, 1'b0, 20'h00DEF, 2'd0, 0, 0, 2, 15, 0, 28'h0ABC14};

        for (int s = 0; s < NS; s++) begin
            env_ptr[s] = '0;
            for (int w = 0; w < NW; w++) begin
                env_valid[s][w] = 0; env_dirty[s][w] = 0; env_tag[s][w] = '0;
                for (int k = 0; k < LW; k++) env_data[s][w][k] = $urandom;
            end
        end
        cfg_rst = 0; cfg_abort = 0; cfg_hold = 0; cfg_stray = 0;
        for (int b = 0; b < 4; b++) begin cfg_wst[b] = 0; cfg_gap[b] = 0; rdata[b] = '0; end

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_miss_ready", miss_ready, 1);
        chk("reset_outputs_zero", |{busy, repl_en, repl_way, mem_wr_valid, mem_wr_addr, mem_wr_data,
            mem_rd_req_valid, mem_rd_addr, fill_we, fill_way, fill_word, fill_data, tag_we,
            tag_wr_valid, tag_wr_tag, refill_done, repl_index}, 0);
        @(posedge clk); #1 rst_n = 1;

        // Stray read response and write ready while idle.
        @(posedge clk); #1;
        mem_rd_resp_valid = 1; mem_rd_data = 32'hDEAD_BEEF; mem_wr_ready = 1;
        #4;
        chk("stray_fill_we", fill_we, 0);
        chk("stray_busy", busy, 0);
        chk("stray_wr_valid", mem_wr_valid, 0);
        @(posedge clk); #1 mem_rd_resp_valid = 0; mem_wr_ready = 0;

        for (int i = 0; i < 4; i++) begin
            env_ptr[vecs[i].idx] = vecs[i].way;
            env_valid[vecs[i].idx][vecs[i].way] = vecs[i].vvalid;
            env_dirty[vecs[i].idx][vecs[i].way] = vecs[i].vdirty;
            env_tag[vecs[i].idx][vecs[i].way]   = vecs[i].vtag;
            for (int b = 0; b < 4; b++) begin
                cfg_wst[b] = (b == 2) ? vecs[i].wst2 : 0;
                cfg_gap[b] = vecs[i].gap;
                rdata[b]   = $urandom;
            end
            cfg_rst = vecs[i].rst;
            prep_expect(vecs[i].idx);
            run_miss(vecs[i].idx, vecs[i].tag);
            check_miss(vecs[i].idx, vecs[i].tag);
            chk($sformatf("vec%0d_done_cycle", i), obs_done, vecs[i].exp_done);
            chk($sformatf("vec%0d_wb_beats", i), obs_wb_addr.size(), vecs[i].exp_wb);
            chk($sformatf("vec%0d_rd_addr", i), obs_rd_addr, vecs[i].exp_rdaddr);
        end

        // Back-to-back: miss_valid held through the first refill, second accepted right after DONE.
        for (int b = 0; b < 4; b++) begin cfg_wst[b] = 0; cfg_gap[b] = 0; rdata[b] = $urandom; end
        cfg_rst = 0; cfg_hold = 1;
        prep_expect(6'd12);
        run_miss(6'd12, 20'h11111);
        check_miss(6'd12, 20'h11111);
        cfg_hold = 0;
        for (int b = 0; b < 4; b++) rdata[b] = $urandom;
        prep_expect(6'd13);
        run_miss(6'd13, 20'h22222);
        check_miss(6'd13, 20'h22222);
        chk("b2b_accept_wait", obs_acc_wait, 0);

        // Reset in the middle of FILL, after beat 1.
        env_valid[20][env_ptr[20]] = 1; env_dirty[20][env_ptr[20]] = 1; env_tag[20][env_ptr[20]] = 20'h0AAAA;
        for (int b = 0; b < 4; b++) rdata[b] = $urandom;
        cfg_abort = 2;
        prep_expect(6'd20);
        run_miss(6'd20, 20'h33333);
        cfg_abort = 0;
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        #4;
        chk("abort_miss_ready", miss_ready, 1);
        chk("abort_outputs_zero", |{busy, repl_en, repl_way, mem_wr_valid, mem_wr_addr, mem_wr_data,
            mem_rd_req_valid, mem_rd_addr, fill_we, fill_way, fill_word, fill_data, tag_we,
            tag_wr_valid, tag_wr_tag, refill_done, repl_index}, 0);
        chk("abort_fill_count", obs_fill_word.size(), 2);
        chk("abort_repl_count", obs_repl_cnt, 0);
        chk("abort_tag_valid_writes", (obs_tw.size() > 1) ? 1 : ((obs_tw.size() == 1) ? obs_tw[0].v : 0), 0);
        chk("abort_line_invalid", env_valid[20][e_way], 0);
        $display("abort idx=20 way=%0d fills=%0d", e_way, obs_fill_word.size());

        // Randomized misses.
        for (int n = 0; n < 30; n++) begin
            logic [IDXW-1:0] idx;
            logic [TAGW-1:0] tag;
            for (int d = 0; d < 3; d++) begin
                int s = $urandom_range(0, 7);
                int w = $urandom_range(0, NW - 1);
                if (env_valid[s][w]) begin
                    env_dirty[s][w] = 1;
                    env_data[s][w][$urandom_range(0, LW - 1)] = $urandom;
                end
            end
            idx = IDXW'($urandom_range(0, 7));
            tag = TAGW'($urandom);
            for (int b = 0; b < 4; b++) begin
                cfg_wst[b] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : 0;
                cfg_gap[b] = $urandom_range(0, 2);
                rdata[b]   = $urandom;
            end
            cfg_rst   = $urandom_range(0, 3);
            cfg_hold  = ($urandom_range(0, 3) == 0);
            cfg_stray = 1;
            prep_expect(idx);
            run_miss(idx, tag);
            check_miss(idx, tag);
        end
        miss_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
